rom_slot_arbiter: RTL and testbench
===================================

Name: rom_slot_arbiter

Overview:
- Time-slot arbiter that shares one synchronous single-port ROM among NUM_CH sample consumers (song players, noise generators).
- Each channel supplies a region base, a region length and a sample index. The block rotates through the channels, forms the absolute ROM address, and returns each channel's word with a one-cycle valid strobe.
- Sits between the audio sources and the Intel ROM IP.
- Adds generalised channel count, per-channel enable, index clamping with error flags, and programmable ROM latency.

Parameters:
- NUM_CH, 3, number of consumer channels (1..16).
- ADDR_W, 16, ROM address width.
- DATA_W, 16, ROM data width.
- ROM_LATENCY, 1, cycles from ROM address sampled to q valid (1 or 2).
- IDLE_SLOTS, 1, extra unused slots appended to each frame (0..15).

Ports:
- CLK_50Mhz  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ch_enable  in  NUM_CH  per-channel read enable.
- ch_index  in  NUM_CH*ADDR_W  sample offset within region; channel c occupies bits [c*ADDR_W +: ADDR_W].
- ch_base  in  NUM_CH*ADDR_W  region start address.
- ch_length  in  NUM_CH*ADDR_W  region size in words.
- err_clear  in  1  one-cycle pulse; clears all range_error bits.
- ch_data  out  NUM_CH*DATA_W  last word fetched per channel.
- ch_valid  out  NUM_CH  one-cycle strobe when ch_data[c] updates.
- range_error  out  NUM_CH  sticky; set when index >= length.
- rom_address  out  ADDR_W  registered address to ROM IP.
- rom_q  in  DATA_W  ROM read data.

Behaviour:
- Reset (async assert, sync release):
  - slot counter = 0.
  - rom_address, ch_data, ch_valid and range_error = 0.
  - Read tag pipeline cleared.
  - Reads in flight at reset never produce a valid strobe.
- Frame: F = NUM_CH + IDLE_SLOTS slots of one cycle each. The slot counter counts 0..F-1 and wraps to 0. Each channel is serviced exactly once per F cycles.
- Slot s < NUM_CH, ch_enable[s] = 1 and ch_length[s] != 0:
  - Sample index, base and length of channel s.
  - offset = index if index < length, else length-1.
  - rom_address <= base + offset, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - Push tag {valid = 1, ch = s} into the pipeline.
- Clamp case (index >= length): range_error[s] <= 1 in the same edge that loads rom_address.
- Skipped slot (ch_enable[s] = 0, ch_length[s] = 0, or idle slot s >= NUM_CH):
  - rom_address holds its previous value.
  - Push an invalid tag.
  - No range_error update for a disabled or zero-length channel.
- Tag pipeline depth: ROM_LATENCY + 1. When a valid tag for channel c exits:
  - ch_data[c] <= rom_q and ch_valid[c] <= 1 for exactly one cycle.
  - Timing: ch_data[c] updates ROM_LATENCY+1 edges after the edge that loaded rom_address.
- At most one ch_valid bit is high in any cycle. ch_data[c] holds between updates.
- err_clear: clears all range_error bits on the next edge. If a set and a clear hit the same bit in the same cycle, the set wins.
- Inputs are sampled only in the owning slot. Changes in other cycles are ignored until the next service.

Test Plan:
- Setup for all scenarios: NUM_CH = 3, IDLE_SLOTS = 1, ROM_LATENCY = 1. ROM model: q = address + 16'h1000, sampled on the registered address.
- Normal rotation:
  - Stimulus: release reset; bases 0/100/200; lengths 50; indices 5/6/7; all enabled.
  - Required: rom_address sequence 5, 106, 207, hold (idle slot), repeating every 4 cycles.
  - Required: ch_valid[0] pulses 2 edges after address 5 is loaded, with ch_data0 = 16'h1005; likewise ch_data1 = 16'h106A, ch_data2 = 16'h10CF.
- Clamp and error:
  - Stimulus: ch_index1 = 60.
  - Required: address 149; range_error[1] = 1, held after the index returns to 6.
  - Required: err_clear pulse → range_error = 0. err_clear in the same cycle as a new clamp → bit stays 1.
- Disable:
  - Stimulus: ch_enable[1] = 0.
  - Required: addresses 5, 5 (hold), 207; ch_valid[1] never asserts; ch_data1 unchanged.
- Zero length:
  - Stimulus: ch_length2 = 0, ch_index2 = 3.
  - Required: no read for ch2, no ch_valid[2], range_error[2] stays 0.
- Address wrap:
  - Stimulus: ch_base0 = 16'hFFF0, ch_index0 = 16'h0020, ch_length0 = 16'h0040.
  - Required: rom_address = 16'h0010, ch_data0 = 16'h1010, no error.
- Mid-flight reset:
  - Stimulus: assert reset_n low one cycle after address 106 is loaded.
  - Required: all outputs 0 immediately; no ch_valid strobe after release until slot 0's read completes; first post-reset address = 5.

Source files
------------

// File: rtl/rom_slot_arbiter.sv
// Round-robin time-slot arbiter sharing one synchronous single-port ROM among NUM_CH consumers.
// Each owning slot clamps the channel's index into its region, issues the read, and tags it for return.
module rom_slot_arbiter #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ROM_LATENCY = 1,
    parameter int unsigned IDLE_SLOTS  = 1
) (
    input  logic                     CLK_50Mhz,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH*ADDR_W-1:0] ch_index,
    input  logic [NUM_CH*ADDR_W-1:0] ch_base,
    input  logic [NUM_CH*ADDR_W-1:0] ch_length,
    input  logic                     err_clear,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        range_error,
    output logic [ADDR_W-1:0]        rom_address,
    input  logic [DATA_W-1:0]        rom_q
);

    localparam int unsigned FRAME  = NUM_CH + IDLE_SLOTS;
    localparam int unsigned SLOT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DEPTH  = ROM_LATENCY + 1;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
    } tag_t;

    logic [SLOT_W-1:0] slot;
    tag_t              tag_pipe [DEPTH];

    logic              svc_c;
    logic [CH_W-1:0]   svc_ch_c;
    logic [ADDR_W-1:0] idx_c, base_c, len_c, offset_c, addr_c;
    logic              clamp_c;
    logic [NUM_CH-1:0] err_next_c;
    tag_t              push_c;

    // Select the owning channel's fields and form the clamped absolute address.
    always_comb begin
        svc_c      = 1'b0;
        svc_ch_c   = '0;
        idx_c      = '0;
        base_c     = '0;
        len_c      = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (slot == SLOT_W'(c)) begin
                svc_c    = ch_enable[c] && (ch_length[c*ADDR_W +: ADDR_W] != '0);
                svc_ch_c = CH_W'(c);
                idx_c    = ch_index[c*ADDR_W +: ADDR_W];
                base_c   = ch_base[c*ADDR_W +: ADDR_W];
                len_c    = ch_length[c*ADDR_W +: ADDR_W];
            end
        end
        clamp_c    = (idx_c >= len_c);
        offset_c   = clamp_c ? (len_c - ADDR_W'(1)) : idx_c;
        addr_c     = base_c + offset_c;
        // A set in the same cycle as a clear must win.
        err_next_c = err_clear ? '0 : range_error;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (svc_c && clamp_c && (svc_ch_c == CH_W'(c))) begin
                err_next_c[c] = 1'b1;
            end
        end
        push_c.valid = svc_c;
        push_c.ch    = svc_ch_c;
    end

    // Slot rotation, address issue, error flags and the read tag pipeline.
    always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            slot        <= '0;
            rom_address <= '0;
            range_error <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            slot        <= (slot == SLOT_W'(FRAME - 1)) ? '0 : slot + SLOT_W'(1);
            range_error <= err_next_c;
            if (svc_c) begin
                rom_address <= addr_c;
            end
            tag_pipe[0] <= push_c;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Capture returning ROM data for the channel whose tag is exiting.
    always_ff @(posedge CLK_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            ch_data  <= '0;
            ch_valid <= '0;
        end else begin
            ch_valid <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (tag_pipe[DEPTH-1].valid && (tag_pipe[DEPTH-1].ch == CH_W'(c))) begin
                    ch_valid[c]                  <= 1'b1;
                    ch_data[c*DATA_W +: DATA_W] <= rom_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_slot_arbiter.sv
// Bench for rom_slot_arbiter: directed scenarios plus random traffic against a timestamped read model.
module tb_rom_slot_arbiter;

    localparam int unsigned F   = 4;
    localparam int unsigned LAT = 1;

    logic        clk;
    logic        reset_n;
    logic [2:0]  en;
    logic [15:0] idx_a [3];
    logic [15:0] base_a [3];
    logic [15:0] len_a [3];
    logic        err_clear;
    logic [47:0] ch_index, ch_base, ch_length, ch_data;
    logic [2:0]  ch_valid, range_error;
    logic [15:0] rom_address, rom_q;

    int total = 0;
    int bad   = 0;

    assign ch_index  = {idx_a[2], idx_a[1], idx_a[0]};
    assign ch_base   = {base_a[2], base_a[1], base_a[0]};
    assign ch_length = {len_a[2], len_a[1], len_a[0]};

    rom_slot_arbiter #(.NUM_CH(3), .ADDR_W(16), .DATA_W(16), .ROM_LATENCY(LAT), .IDLE_SLOTS(1)) dut (
        .CLK_50Mhz(clk), .reset_n(reset_n), .ch_enable(en), .ch_index(ch_index),
        .ch_base(ch_base), .ch_length(ch_length), .err_clear(err_clear), .ch_data(ch_data),
        .ch_valid(ch_valid), .range_error(range_error), .rom_address(rom_address), .rom_q(rom_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM IP stand-in: one cycle of latency, q = address + 0x1000.
    always @(posedge clk) rom_q <= rom_address + 16'h1000;

    // Reference model: edge k services slot k mod F; each read lands LAT+1 edges later.
    typedef struct { int unsigned due; int ch; logic [15:0] addr; } rd_t;
    rd_t         pend [$];
    int unsigned k;
    logic [15:0] m_addr;
    logic [2:0]  m_err, m_valid;
    logic [15:0] m_data [3];

    task automatic model_reset();
        k = 0; m_addr = '0; m_err = '0; m_valid = '0;
        for (int c = 0; c < 3; c++) m_data[c] = '0;
        pend.delete();
    endtask

    task automatic model_edge();
        int unsigned s;
        logic [15:0] off;
        rd_t r;
        s = k % F;
        m_valid = '0;
        while (pend.size() > 0 && pend[0].due == k) begin
            r = pend.pop_front();
            m_valid[r.ch] = 1'b1;
            m_data[r.ch]  = r.addr + 16'h1000;
        end
        if (err_clear) m_err = '0;
        if (s < 3 && en[s] && len_a[s] != 0) begin
            off    = (idx_a[s] < len_a[s]) ? idx_a[s] : len_a[s] - 16'd1;
            m_addr = base_a[s] + off;
            if (idx_a[s] >= len_a[s]) m_err[s] = 1'b1;
            r.due = k + LAT + 1; r.ch = int'(s); r.addr = m_addr;
            pend.push_back(r);
        end
        k++;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
    endtask

    // Advance until the edge just taken serviced slot s.
    task automatic align(input int unsigned s);
        for (int i = 0; i < 5; i++) begin
            step();
            if ((k - 1) % F == s) break;
        end
    endtask

    task automatic set_default_inputs();
        en = 3'b111; err_clear = 1'b0;
        base_a[0] = 16'd0; base_a[1] = 16'd100; base_a[2] = 16'd200;
        len_a[0]  = 16'd50; len_a[1] = 16'd50;  len_a[2]  = 16'd50;
        idx_a[0]  = 16'd5;  idx_a[1] = 16'd6;   idx_a[2]  = 16'd7;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_default_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        total++; if (rom_address !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", rom_address); end
        total++; if (ch_data !== 48'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", ch_data); end
        total++; if (ch_valid !== 3'b0) begin bad++; $display("FAIL reset_valid got=%b exp=000", ch_valid); end
        total++; if (range_error !== 3'b0) begin bad++; $display("FAIL reset_err got=%b exp=000", range_error); end
    endtask

    task automatic test_rotation();
        logic [15:0] exp_addr [4];
        logic [15:0] exp_data [3];
        logic [2:0]  exp_v;
        int unsigned e;
        exp_addr[0] = 16'd5; exp_addr[1] = 16'd106; exp_addr[2] = 16'd207; exp_addr[3] = 16'd207;
        exp_data[0] = 16'h1005; exp_data[1] = 16'h106A; exp_data[2] = 16'h10CF;
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            e = k - 1;
            exp_v = '0;
            if (e >= 2) exp_v = (e % F == 2) ? 3'b001 : (e % F == 3) ? 3'b010 : (e % F == 0) ? 3'b100 : 3'b000;
            total++; if (rom_address !== exp_addr[e % F]) begin bad++; $display("FAIL rot_addr edge=%0d got=%0d exp=%0d", e, rom_address, exp_addr[e % F]); end
            total++; if (ch_valid !== exp_v) begin bad++; $display("FAIL rot_valid edge=%0d got=%b exp=%b", e, ch_valid, exp_v); end
            for (int c = 0; c < 3; c++) begin
                if (exp_v[c]) begin
                    total++; if (ch_data[c*16 +: 16] !== exp_data[c]) begin bad++; $display("FAIL rot_data ch=%0d got=%h exp=%h", c, ch_data[c*16 +: 16], exp_data[c]); end
                end
            end
        end
    endtask

    task automatic test_clamp();
        idx_a[1] = 16'd60;
        align(1);
        total++; if (rom_address !== 16'd149) begin bad++; $display("FAIL clamp_addr got=%0d exp=149", rom_address); end
        total++; if (range_error !== 3'b010) begin bad++; $display("FAIL clamp_err got=%b exp=010", range_error); end
        idx_a[1] = 16'd6;
        repeat (4) step();
        total++; if (range_error !== 3'b010) begin bad++; $display("FAIL clamp_sticky got=%b exp=010", range_error); end
        err_clear = 1'b1; step(); err_clear = 1'b0;
        total++; if (range_error !== 3'b000) begin bad++; $display("FAIL clamp_clear got=%b exp=000", range_error); end
        align(0);
        idx_a[1] = 16'd60; err_clear = 1'b1;
        step();
        err_clear = 1'b0; idx_a[1] = 16'd6;
        total++; if (range_error !== 3'b010) begin bad++; $display("FAIL clamp_set_wins got=%b exp=010", range_error); end
        err_clear = 1'b1; step(); err_clear = 1'b0;
        total++; if (range_error !== m_err) begin bad++; $display("FAIL clamp_clear2 got=%b exp=%b", range_error, m_err); end
        repeat (4) step();
    endtask

    task automatic test_disable();
        logic [15:0] exp_addr [3];
        exp_addr[0] = 16'd5; exp_addr[1] = 16'd5; exp_addr[2] = 16'd207;
        align(3);
        en[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (rom_address !== exp_addr[i]) begin bad++; $display("FAIL dis_addr i=%0d got=%0d exp=%0d", i, rom_address, exp_addr[i]); end
        end
        for (int i = 0; i < 8; i++) begin
            step();
            total++; if (ch_valid[1] !== 1'b0 || ch_data[31:16] !== 16'h106A) begin
                bad++; $display("FAIL dis_ch1 i=%0d valid=%b data=%h exp valid=0 data=106a", i, ch_valid[1], ch_data[31:16]);
            end
        end
        en[1] = 1'b1;
    endtask

    task automatic test_zero_len();
        align(0);
        len_a[2] = 16'd0; idx_a[2] = 16'd3;
        for (int i = 0; i < 8; i++) begin
            step();
            total++; if (ch_valid[2] !== 1'b0 || range_error[2] !== 1'b0) begin
                bad++; $display("FAIL zl_ch2 i=%0d valid=%b err=%b exp 0/0", i, ch_valid[2], range_error[2]);
            end
            if ((k - 1) % F == 2) begin
                total++; if (rom_address !== 16'd106) begin bad++; $display("FAIL zl_hold got=%0d exp=106", rom_address); end
            end
        end
        len_a[2] = 16'd50; idx_a[2] = 16'd7;
        repeat (4) step();
    endtask

    task automatic test_wrap();
        align(3);
        base_a[0] = 16'hFFF0; idx_a[0] = 16'h0020; len_a[0] = 16'h0040;
        step();
        total++; if (rom_address !== 16'h0010) begin bad++; $display("FAIL wrap_addr got=%h exp=0010", rom_address); end
        repeat (2) step();
        total++; if (ch_valid !== 3'b001 || ch_data[15:0] !== 16'h1010) begin
            bad++; $display("FAIL wrap_data valid=%b data=%h exp 001/1010", ch_valid, ch_data[15:0]);
        end
        total++; if (range_error !== 3'b000) begin bad++; $display("FAIL wrap_err got=%b exp=000", range_error); end
        base_a[0] = 16'd0; idx_a[0] = 16'd5; len_a[0] = 16'd50;
        repeat (4) step();
    endtask

    task automatic test_midflight_reset();
        align(1);
        total++; if (rom_address !== 16'd106) begin bad++; $display("FAIL mf_pre got=%0d exp=106", rom_address); end
        step();
        reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (rom_address !== 16'h0 || ch_data !== 48'h0 || ch_valid !== 3'b0 || range_error !== 3'b0) begin
            bad++; $display("FAIL mf_clear addr=%h data=%h valid=%b err=%b exp all 0", rom_address, ch_data, ch_valid, range_error);
        end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ch_valid !== ((i == 2) ? 3'b001 : 3'b000)) begin bad++; $display("FAIL mf_valid i=%0d got=%b", i, ch_valid); end
            if (i == 0) begin
                total++; if (rom_address !== 16'd5) begin bad++; $display("FAIL mf_first_addr got=%0d exp=5", rom_address); end
            end
            if (i == 2) begin
                total++; if (ch_data[15:0] !== 16'h1005) begin bad++; $display("FAIL mf_data got=%h exp=1005", ch_data[15:0]); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 3; c++) begin
                en[c]     = ($urandom_range(0, 3) != 0);
                len_a[c]  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 64));
                idx_a[c]  = 16'($urandom_range(0, 80));
                base_a[c] = 16'($urandom);
            end
            err_clear = ($urandom_range(0, 7) == 0);
            step();
            total++; if (rom_address !== m_addr) begin bad++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, rom_address, m_addr); end
            total++; if (range_error !== m_err) begin bad++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, range_error, m_err); end
            total++; if (ch_valid !== m_valid) begin bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, ch_valid, m_valid); end
            for (int c = 0; c < 3; c++) begin
                total++; if (ch_data[c*16 +: 16] !== m_data[c]) begin bad++; $display("FAIL rnd_data i=%0d ch=%0d got=%h exp=%h", i, c, ch_data[c*16 +: 16], m_data[c]); end
            end
        end
        err_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_clamp();
        test_disable();
        test_zero_len();
        test_wrap();
        test_midflight_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
